// File: rtl/s2_arb_pkg.sv
// Shared types and helpers for the S2 select-cell round-robin arbiter.
package s2_arb_pkg;

    localparam int unsigned NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Cell pin order {A1,B1,A0,B0}; the cell decodes S1=A1|B1, S0=A0&B0.
    function automatic logic [3:0] sel_to_pins(input logic [1:0] sel);
        return {sel[1], 1'b0, sel[0], sel[0]};
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick: first set req bit after ptr, wrapping.
module rr_pick4
    import s2_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!any && req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/s2_share_arb.sv
// Round-robin burst arbiter sharing one registered N-bit 4:1 S2 select cell.
module s2_share_arb
    import s2_arb_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned BURST = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [3:0]   req,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    output logic [3:0]   gnt,
    output logic         busy,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic [1:0]   out_src
);

    localparam logic [3:0] CNT_INIT = 4'(BURST - 1);

    state_t       state_q, state_d;
    logic [1:0]   sel_q, sel_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] out_q;
    logic         out_valid_q;
    logic [1:0]   out_src_q;

    logic [1:0]   pick_ptr, win;
    logic         any, beat, burst_end;
    logic [3:0]   pins;
    logic [1:0]   cell_sel;
    logic [N-1:0] cell_d;

    // At burst end the pointer is about to become sel, so pick from sel directly.
    assign pick_ptr = (state_q == XFER) ? sel_q : ptr_q;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .win (win),
        .any (any)
    );

    assign beat      = (state_q == XFER) && req[sel_q];
    assign burst_end = (state_q == XFER) && (!req[sel_q] || (cnt_q == '0));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = XFER;
                    sel_d   = win;
                    cnt_d   = CNT_INIT;
                end
            end
            XFER: begin
                if (burst_end) begin
                    ptr_d = sel_q;
                    if (any) begin
                        sel_d = win;
                        cnt_d = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pins     = sel_to_pins(sel_q);
    assign cell_sel = {pins[3] | pins[2], pins[1] & pins[0]};

    always_comb begin
        cell_d = '0;
        unique case (cell_sel)
            2'd0: cell_d = D0;
            2'd1: cell_d = D1;
            2'd2: cell_d = D2;
            2'd3: cell_d = D3;
            default: cell_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= 2'd3;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= beat;
            if (beat) begin
                out_q     <= cell_d;
                out_src_q <= sel_q;
            end
        end
    end

    assign busy      = (state_q == XFER);
    assign gnt       = busy ? (4'b0001 << sel_q) : 4'b0000;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_s2_share_arb.sv
// Directed self-checking bench for s2_share_arb (BURST=4 and BURST=2 instances).
module tb_s2_share_arb;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] D0 = '0, D1 = '0, D2 = '0, D3 = '0;

    logic [3:0] gnt4, gnt2;
    logic       busy4, busy2;
    logic [7:0] out4, out2;
    logic       val4, val2;
    logic [1:0] src4, src2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    s2_share_arb #(.N(8), .BURST(4)) u_b4 (
        .clk(clk), .clr(clr), .req(req),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .gnt(gnt4), .busy(busy4), .out(out4), .out_valid(val4), .out_src(src4)
    );

    s2_share_arb #(.N(8), .BURST(2)) u_b2 (
        .clk(clk), .clr(clr), .req(req),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .gnt(gnt2), .busy(busy2), .out(out2), .out_valid(val2), .out_src(src2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        req = '0;
        tick();
        tick();
        clr = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        req = 4'b1111;
        D0 = 8'h11; D1 = 8'h22; D2 = 8'h33; D3 = 8'h44;
        tick();
        tick();
        checks++; if (gnt4 !== 4'b0000) begin failures++; $display("FAIL reset_gnt4 got=%b exp=0000", gnt4); end
        checks++; if (out4 !== 8'h00) begin failures++; $display("FAIL reset_out4 got=%h exp=00", out4); end
        checks++; if (val4 !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%b exp=0", val4); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
        checks++; if (gnt2 !== 4'b0000) begin failures++; $display("FAIL reset_gnt2 got=%b exp=0000", gnt2); end
        checks++; if (val2 !== 1'b0) begin failures++; $display("FAIL reset_valid2 got=%b exp=0", val2); end
        clr = 1'b1;
        tick();
        checks++; if (gnt4 !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt4 got=%b exp=0001", gnt4); end
        checks++; if (gnt2 !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt2 got=%b exp=0001", gnt2); end
        checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL reset_first_busy4 got=%b exp=1", busy4); end
        checks++; if (val4 !== 1'b0) begin failures++; $display("FAIL reset_first_valid4 got=%b exp=0", val4); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        D2  = 8'h10;
        tick();
        checks++; if (gnt4 !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt4); end
        checks++; if (val4 !== 1'b0) begin failures++; $display("FAIL single_lat got=%b exp=0", val4); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (val4 !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%b exp=1", k, val4); end
            checks++; if (out4 !== 8'(8'h10 + k)) begin failures++; $display("FAIL single_out[%0d] got=%h exp=%h", k, out4, 8'(8'h10 + k)); end
            checks++; if (src4 !== 2'd2) begin failures++; $display("FAIL single_src[%0d] got=%0d exp=2", k, src4); end
            checks++; if (gnt4 !== 4'b0100) begin failures++; $display("FAIL single_gnt_hold[%0d] got=%b exp=0100", k, gnt4); end
            D2 = D2 + 8'd1;
        end
        tick();
        checks++; if (val4 !== 1'b1) begin failures++; $display("FAIL single_regrant_valid got=%b exp=1", val4); end
        checks++; if (out4 !== 8'h14) begin failures++; $display("FAIL single_regrant_out got=%h exp=14", out4); end
        req = '0;
    endtask

    task automatic test_fairness();
        logic [1:0] eg, es;
        logic [7:0] ed;
        do_reset();
        D0 = 8'hA0; D1 = 8'hB1; D2 = 8'hC2; D3 = 8'hD3;
        req = 4'b1111;
        for (int t = 1; t <= 20; t++) begin
            tick();
            eg = 2'((t - 1) / 2);
            checks++; if (gnt2 !== (4'b0001 << eg)) begin failures++; $display("FAIL rr_gnt[t=%0d] got=%b exp=%b", t, gnt2, 4'b0001 << eg); end
            if (t >= 2) begin
                es = 2'((t - 2) / 2);
                case (es)
                    2'd0: ed = 8'hA0;
                    2'd1: ed = 8'hB1;
                    2'd2: ed = 8'hC2;
                    default: ed = 8'hD3;
                endcase
                checks++; if (val2 !== 1'b1) begin failures++; $display("FAIL rr_valid[t=%0d] got=%b exp=1", t, val2); end
                checks++; if (src2 !== es) begin failures++; $display("FAIL rr_src[t=%0d] got=%0d exp=%0d", t, src2, es); end
                checks++; if (out2 !== ed) begin failures++; $display("FAIL rr_out[t=%0d] got=%h exp=%h", t, out2, ed); end
            end
        end
        req = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        D1 = 8'h5A; D3 = 8'h3C;
        req = 4'b1010;
        tick();
        checks++; if (gnt4 !== 4'b0010) begin failures++; $display("FAIL wd_gnt1 got=%b exp=0010", gnt4); end
        tick();
        checks++; if (val4 !== 1'b1 || out4 !== 8'h5A || src4 !== 2'd1) begin failures++; $display("FAIL wd_beat1 got=%b/%h/%0d exp=1/5a/1", val4, out4, src4); end
        req = 4'b1000;
        tick();
        checks++; if (gnt4 !== 4'b1000) begin failures++; $display("FAIL wd_gnt3 got=%b exp=1000", gnt4); end
        checks++; if (val4 !== 1'b0) begin failures++; $display("FAIL wd_novalid got=%b exp=0", val4); end
        checks++; if (out4 !== 8'h5A) begin failures++; $display("FAIL wd_hold got=%h exp=5a", out4); end
        tick();
        checks++; if (val4 !== 1'b1 || out4 !== 8'h3C || src4 !== 2'd3) begin failures++; $display("FAIL wd_beat3 got=%b/%h/%0d exp=1/3c/3", val4, out4, src4); end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        D0 = 8'h55;
        req = 4'b0001;
        tick();
        tick();
        checks++; if (val4 !== 1'b1 || out4 !== 8'h55) begin failures++; $display("FAIL mid_beat1 got=%b/%h exp=1/55", val4, out4); end
        clr = 1'b0;
        tick();
        checks++; if (gnt4 !== 4'b0000) begin failures++; $display("FAIL mid_gnt got=%b exp=0000", gnt4); end
        checks++; if (out4 !== 8'h00) begin failures++; $display("FAIL mid_out got=%h exp=00", out4); end
        checks++; if (val4 !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", val4); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy4); end
        clr = 1'b1;
        tick();
        checks++; if (gnt4 !== 4'b0001) begin failures++; $display("FAIL mid_regrant got=%b exp=0001", gnt4); end
        req = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        D1 = 8'h61; D3 = 8'h63;
        req = 4'b1000;
        tick();
        checks++; if (gnt2 !== 4'b1000) begin failures++; $display("FAIL wrap_gnt3 got=%b exp=1000", gnt2); end
        tick();
        req = 4'b1010;
        tick();
        checks++; if (gnt2 !== 4'b0010) begin failures++; $display("FAIL wrap_gnt1 got=%b exp=0010", gnt2); end
        checks++; if (src2 !== 2'd3 || out2 !== 8'h63) begin failures++; $display("FAIL wrap_src3 got=%0d/%h exp=3/63", src2, out2); end
        tick();
        checks++; if (src2 !== 2'd1 || out2 !== 8'h61) begin failures++; $display("FAIL wrap_src1 got=%0d/%h exp=1/61", src2, out2); end
        tick();
        checks++; if (gnt2 !== 4'b1000) begin failures++; $display("FAIL wrap_back3 got=%b exp=1000", gnt2); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_withdraw();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s2_share_arb.md
Name: s2_share_arb

Overview:
- Round-robin controller that shares one registered N-bit 4:1 select cell (the S2-style mux-plus-register) among four requesters.
- Each granted requester gets a burst of up to BURST beats.
- The block drives the cell select pins from its grant index, so each beat's data reaches the registered output one cycle later, tagged with its source index.
- Sits between the four data producers and the single downstream consumer of the cell output.

Parameters:
- N, 8: data width of D0..D3 and out.
- BURST, 4: maximum beats per grant; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  synchronous, active-low reset; clr=0 at a posedge clears all state.
- req  in  4  per-requester request; must be held while the requester still has data.
- D0, D1, D2, D3  in  N each  requester data words.
- gnt  out  4  one-hot grant; requester i advances its data after any edge where gnt[i]&req[i]=1.
- busy  out  1  1 while a grant is active (state XFER).
- out  out  N  registered cell output.
- out_valid  out  1  1 for exactly one cycle per beat, aligned with out.
- out_src  out  2  requester index of the current out word.

Behaviour:
- Reset (clr=0 at posedge):
  - state=IDLE, gnt=0, busy=0, ptr=3 (so requester 0 has first priority), cnt=0, sel=0.
  - out=0, out_valid=0, out_src=0.
  - Reset mid-burst aborts the burst; no further out_valid.
- Round-robin pick, combinational: search req starting at (ptr+1) mod 4 and wrapping; first set bit wins. No set bit means no winner.
- IDLE:
  - If any req is high, register sel=winner, gnt=onehot(winner), cnt=BURST-1; go to XFER.
  - The grant is visible the cycle after req is first sampled.
- XFER: a beat is a cycle with req[sel]=1.
  - On a beat, the cell register loads D[sel]; at that edge out_src<=sel and out_valid<=1.
  - On a non-beat cycle, out holds its value and out_valid<=0.
  - Latency: data presented on a beat cycle appears on out with out_valid=1 in the next cycle.
- Burst end, evaluated each XFER cycle:
  - Last beat (beat & cnt==0), or req[sel]=0 (requester withdrew, no beat that cycle): set ptr<=sel, then re-pick with the updated ptr.
  - If there is a winner, go straight to the next grant (back-to-back, no dead cycle) with cnt=BURST-1.
  - If there is no winner, go to IDLE with gnt=0.
  - Otherwise, on a beat, cnt<=cnt-1.
- Cell select drive: sel[1] is presented as A1=sel[1], B1=0. sel[0] is presented as A0=B0=sel[0]. In IDLE, sel holds its last value.
- A sole requester can be re-granted immediately after its burst ends; the round-robin pick returns it again.
- Simultaneous events:
  - Requests arriving mid-burst wait until burst end.
  - A req rising on the same cycle as burst end of another requester competes in that re-pick.
- Invariants: gnt is one-hot or zero; gnt!=0 iff busy=1; out_valid never asserts while clr=0.

Decomposition:
- Package s2_arb_pkg holds:
  - state constants IDLE=1'b0 and XFER=1'b1;
  - NREQ=4;
  - a function sel_to_pins(sel) returning {A1,B1,A0,B0}.
- One sub-module, rr_pick4: combinational, inputs req[3:0] and ptr[1:0], outputs win[1:0] and any.
- The FSM, counter and output register stay in s2_share_arb.

Test Plan:
- Reset: hold clr=0 for 2 cycles with req=4'b1111 -> gnt=0, out=0, out_valid=0, busy=0. After release, the first grant is gnt=4'b0001.
- Single requester: N=8, BURST=4, req=4'b0100, D2 incrementing from 8'h10 on each beat -> out = 10, 11, 12, 13 with out_src=2 on 4 consecutive cycles. Then gnt=0100 again with no gap, since req is still high.
- Round-robin fairness: req=4'b1111 held for 20 cycles, BURST=2 -> grant order 0, 1, 2, 3, 0; each grant gives exactly 2 out_valid pulses; no idle cycle between bursts.
- Early withdraw: requester 1 granted, drops req[1] after 1 beat while req[3]=1 -> exactly 1 beat from source 1. The next cycle gives gnt=4'b1000 and out_valid=0 for the withdraw cycle.
- Reset mid-burst: clr=0 during the 2nd beat of requester 0 -> next cycle gnt=0, out=0, out_valid=0. After release with req=4'b0001, requester 0 is granted again (ptr reset to 3).
- Wrap and priority: ptr=3 after requester 3's burst, req=4'b1010 -> requester 1 is granted, then requester 3.
